// File: rtl/gf571_pkg.sv
// Shared constants for the GF(2) polynomial multiplier blocks: limb/operand/product
// widths and the Karatsuba controller state encoding.
package gf571_pkg;

   localparam int GF_LIMB_W = 71;
   localparam int GF_OP_W   = 2 * GF_LIMB_W;
   localparam int GF_RES_W  = 2 * GF_OP_W - 1;

   typedef logic [1:0] km_state_t;

   localparam km_state_t ST_IDLE = 2'd0;
   localparam km_state_t ST_MUL  = 2'd1;
   localparam km_state_t ST_FIN  = 2'd2;
   localparam km_state_t ST_DONE = 2'd3;

   localparam logic [1:0] CNT_LO  = 2'd0;
   localparam logic [1:0] CNT_HI  = 2'd1;
   localparam logic [1:0] CNT_MID = 2'd2;

endpackage

// File: rtl/mult71.sv
// Limb carry-less multiplier: W x W bits over GF(2), product registered (1-cycle latency).
module mult71
#(
   parameter int W = gf571_pkg::GF_LIMB_W
)(
   input  logic           clk,
   input  logic           rst_n,
   input  logic [W-1:0]   x,
   input  logic [W-1:0]   y,
   output logic [2*W-2:0] p
);

   logic [2*W-2:0] prod_d;
   logic [2*W-2:0] prod_q;

   // shift-and-xor partial products
   always_comb begin
      prod_d = '0;
      for (int i = 0; i < W; i++) begin
         if (y[i]) begin
            prod_d = prod_d ^ ({{(W-1){1'b0}}, x} << i);
         end else begin
            prod_d = prod_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q <= '0;
      end else begin
         prod_q <= prod_d;
      end
   end

   assign p = prod_q;

endmodule

// File: rtl/kmul142_ctrl.sv
// One-level Karatsuba controller: three passes (L, H, M) through a shared limb
// multiplier, then a post-combine into the unreduced 2*OP_W-1 bit product.
module kmul142_ctrl
#(
   parameter int LIMB_W = gf571_pkg::GF_LIMB_W,
   parameter int OP_W   = 2 * LIMB_W,
   parameter int RES_W  = 2 * OP_W - 1
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [OP_W-1:0]  a,
   input  logic [OP_W-1:0]  b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [RES_W-1:0] res
);
   import gf571_pkg::*;

   localparam int PW = 2 * LIMB_W - 1;

   km_state_t        state_q, state_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [OP_W-1:0]  a_q, a_d, b_q, b_d;
   logic [PW-1:0]    l_q, l_d, h_q, h_d;
   logic [RES_W-1:0] res_q, res_d;
   logic             res_valid_q, res_valid_d;

   logic [LIMB_W-1:0] mul_x_s, mul_y_s;
   logic [PW-1:0]     mul_p_s;
   logic [RES_W-1:0]  comb_s;

   mult71 #(.W(LIMB_W)) u_mult (
      .clk   (clk),
      .rst_n (rst_n),
      .x     (mul_x_s),
      .y     (mul_y_s),
      .p     (mul_p_s)
   );

   // limb operand selection; the multiplier sees zeros outside MUL
   always_comb begin
      mul_x_s = '0;
      mul_y_s = '0;
      if (state_q == ST_MUL) begin
         case (cnt_q)
            CNT_LO: begin
               mul_x_s = a_q[LIMB_W-1:0];
               mul_y_s = b_q[LIMB_W-1:0];
            end
            CNT_HI: begin
               mul_x_s = a_q[OP_W-1:LIMB_W];
               mul_y_s = b_q[OP_W-1:LIMB_W];
            end
            CNT_MID: begin
               mul_x_s = a_q[LIMB_W-1:0] ^ a_q[OP_W-1:LIMB_W];
               mul_y_s = b_q[LIMB_W-1:0] ^ b_q[OP_W-1:LIMB_W];
            end
            default: begin
               mul_x_s = '0;
               mul_y_s = '0;
            end
         endcase
      end else begin
         mul_x_s = '0;
         mul_y_s = '0;
      end
   end

   // post-combine in FIN: the multiplier output holds M at that point
   always_comb begin
      comb_s = {{(RES_W-PW){1'b0}}, l_q}
             ^ ({{(RES_W-PW){1'b0}}, (mul_p_s ^ l_q ^ h_q)} << LIMB_W)
             ^ ({{(RES_W-PW){1'b0}}, h_q} << OP_W);
   end

   // sequencing: accept, three limb passes, combine, result handshake
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      l_d         = l_q;
      h_d         = h_q;
      res_d       = res_q;
      res_valid_d = res_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (start_valid) begin
               a_d     = a;
               b_d     = b;
               cnt_d   = CNT_LO;
               state_d = ST_MUL;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL: begin
            if (cnt_q == CNT_HI) begin
               l_d = mul_p_s;
            end else begin
               l_d = l_q;
            end
            if (cnt_q == CNT_MID) begin
               h_d     = mul_p_s;
               cnt_d   = CNT_LO;
               state_d = ST_FIN;
            end else begin
               cnt_d   = cnt_q + 2'd1;
            end
         end
         ST_FIN: begin
            res_d       = comb_s;
            res_valid_d = 1'b1;
            state_d     = ST_DONE;
         end
         ST_DONE: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               state_d     = ST_DONE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            cnt_d       = CNT_LO;
            res_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 2'd0;
         a_q         <= '0;
         b_q         <= '0;
         l_q         <= '0;
         h_q         <= '0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         l_q         <= l_d;
         h_q         <= h_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
      end
   end

   assign start_ready = (state_q == ST_IDLE);
   assign res_valid   = res_valid_q;
   assign res         = res_q;

endmodule

// File: tb/tb_kmul142_ctrl.sv
// Directed and random checks of kmul142_ctrl against a bit-serial carry-less reference.
module tb_kmul142_ctrl;

   localparam int OW = 142;
   localparam int RW = 283;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_valid;
   logic          start_ready;
   logic [OW-1:0] a;
   logic [OW-1:0] b;
   logic          res_valid;
   logic          res_ready;
   logic [RW-1:0] res;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   kmul142_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a           (a),
      .b           (b),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res         (res)
   );

   task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [RW-1:0] ref_clmul(input logic [OW-1:0] x, input logic [OW-1:0] y);
      logic [RW-1:0] r;
      r = '0;
      for (int i = 0; i < OW; i++) begin
         if (y[i]) r = r ^ ({{(RW-OW){1'b0}}, x} << i);
      end
      return r;
   endfunction

   function automatic logic [OW-1:0] rnd_op();
      logic [159:0] w;
      w = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return w[OW-1:0];
   endfunction

   task automatic do_op(input string tag, input logic [OW-1:0] ta, input logic [OW-1:0] tb,
                        input logic [RW-1:0] exp, input int hold);
      int lat;
      @(negedge clk);
      check({tag, "_ready"}, start_ready, 1'b1);
      start_valid = 1'b1;
      a = ta;
      b = tb;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      a = rnd_op();
      b = rnd_op();
      lat = 0;
      for (int i = 1; i <= 8 && lat == 0; i++) begin
         @(posedge clk);
         #1;
         if (res_valid) lat = i;
      end
      check({tag, "_lat"}, lat, 32'd4);
      check({tag, "_res"}, res, exp);
      if (hold > 0) begin
         res_ready = 1'b0;
         for (int k = 0; k < hold; k++) begin
            start_valid = 1'b1;
            a = rnd_op();
            b = rnd_op();
            @(posedge clk);
            #1;
            check({tag, "_hold_res"}, res, exp);
            check({tag, "_hold_rdy"}, start_ready, 1'b0);
            check({tag, "_hold_vld"}, res_valid, 1'b1);
         end
         start_valid = 1'b0;
         res_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      check({tag, "_post_vld"}, res_valid, 1'b0);
      check({tag, "_post_rdy"}, start_ready, 1'b1);
   endtask

   initial begin
      logic [OW-1:0] va, vb, ra, rb;
      logic [RW-1:0] ve;
      rst_n = 1'b0;
      start_valid = 1'b0;
      res_ready = 1'b1;
      a = '0;
      b = '0;
      #12;
      check("rst_vld", res_valid, 1'b0);
      check("rst_res", res, '0);
      check("rst_rdy", start_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      do_op("one", 142'd1, 142'd1, 283'd1, 0);
      do_op("three", 142'd3, 142'd3, 283'd5, 0);

      va = (142'd1 << 70) | (142'd1 << 71);
      vb = 142'd1 << 71;
      ve = (283'd1 << 141) | (283'd1 << 142);
      do_op("limb_carry", va, vb, ve, 0);

      va = 142'd1 << 141;
      ve = 283'd1 << 282;
      do_op("top_bit", va, va, ve, 0);

      va = '1;
      ve = {141'd0, va};
      do_op("all_ones", va, 142'd1, ve, 0);

      va = rnd_op();
      vb = rnd_op();
      do_op("backpressure", va, vb, ref_clmul(va, vb), 10);
      va = rnd_op();
      vb = rnd_op();
      do_op("after_bp", va, vb, ref_clmul(va, vb), 0);

      // reset during MUL count 1
      @(negedge clk);
      start_valid = 1'b1;
      a = 142'd7;
      b = 142'd9;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_vld", res_valid, 1'b0);
      check("mid_rst_res", res, '0);
      @(negedge clk);
      rst_n = 1'b1;
      check("mid_rst_rdy", start_ready, 1'b1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         check("mid_rst_no_vld", res_valid, 1'b0);
      end
      do_op("after_rst", 142'd3, 142'd3, 283'd5, 0);

      for (int n = 0; n < 500; n++) begin
         ra = rnd_op();
         rb = rnd_op();
         do_op("rand", ra, rb, ref_clmul(ra, rb), int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
